// File: rtl/rr_arbiter8_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: state encoding,
// requester count and index width.
package rr_arbiter8_pkg;
    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;
endpackage

// File: rtl/rr_arbiter8_decoder3to8.sv
// Binary index to one-hot conversion used to form the registered grant vector.
module decoder3to8
    import rr_arbiter8_pkg::*;
(
    input  logic [IDX_W-1:0]   idx,
    output logic [NUM_REQ-1:0] onehot
);
    always_comb begin
        onehot      = '0;
        onehot[idx] = 1'b1;
    end
endmodule

// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter with a bounded hold time and one
// mandatory idle cycle between owners.
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t             state, state_next;
    logic [IDX_W-1:0]   ptr, ptr_next;
    logic [7:0]         hold_cnt, hold_cnt_next;
    logic [IDX_W-1:0]   idx_next;
    logic               valid_next;
    logic [NUM_REQ-1:0] onehot_next;
    logic [IDX_W-1:0]   sel;
    logic               found;
    logic               release_now;

    // Search upward from ptr, wrapping 7->0; first set request wins.
    always_comb begin
        found = 1'b0;
        sel   = ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[ptr + IDX_W'(i)]) begin
                found = 1'b1;
                sel   = ptr + IDX_W'(i);
            end
        end
    end

    // done, a dropped request and timeout all collapse into one release.
    assign release_now = done || !req[grant_idx] || (hold_cnt == HOLD_LAST);

    always_comb begin
        state_next    = state;
        ptr_next      = ptr;
        hold_cnt_next = 8'd0;
        idx_next      = grant_idx;
        valid_next    = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_next = BUSY;
                    idx_next   = sel;
                    ptr_next   = sel + IDX_W'(1);
                    valid_next = 1'b1;
                end
            end
            BUSY: begin
                if (release_now) begin
                    state_next = IDLE;
                end else begin
                    hold_cnt_next = hold_cnt + 8'd1;
                    valid_next    = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    decoder3to8 u_dec (
        .idx    (idx_next),
        .onehot (onehot_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            hold_cnt    <= 8'd0;
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
        end else begin
            state       <= state_next;
            ptr         <= ptr_next;
            hold_cnt    <= hold_cnt_next;
            grant       <= valid_next ? onehot_next : '0;
            grant_idx   <= idx_next;
            grant_valid <= valid_next;
        end
    end
endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8 built with a short hold limit of 4 cycles.
module tb_rr_arbiter8;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic       done = 1'b0;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;

    int total = 0;
    int bad   = 0;

    rr_arbiter8 #(.MAX_HOLD(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = 8'h00;
        done = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 8'hFF;
        step();
        total++;
        if (grant !== 8'h00 || grant_valid !== 1'b0 || grant_idx !== 3'd0) begin
            bad++;
            $display("FAIL reset: grant=%h valid=%b idx=%0d want 00/0/0", grant, grant_valid, grant_idx);
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        req = 8'h04;
        step();
        total++;
        if (grant !== 8'h04 || grant_idx !== 3'd2 || grant_valid !== 1'b1) begin
            bad++;
            $display("FAIL single_grant: grant=%h idx=%0d valid=%b want 04/2/1", grant, grant_idx, grant_valid);
        end
        done = 1'b1;
        step();
        total++;
        if (grant !== 8'h00 || grant_valid !== 1'b0 || grant_idx !== 3'd2) begin
            bad++;
            $display("FAIL single_release: grant=%h valid=%b idx=%0d want 00/0/2", grant, grant_valid, grant_idx);
        end
        done = 1'b0;
        req  = 8'h00;
        step();
    endtask

    task automatic test_rotation();
        logic [7:0] exp;
        do_reset();
        req  = 8'hFF;
        done = 1'b1;
        for (int k = 0; k < 9; k++) begin
            exp = 8'h01 << (k % 8);
            step();
            total++;
            if (grant !== exp || grant_idx !== 3'(k % 8) || grant_valid !== 1'b1) begin
                bad++;
                $display("FAIL rotation_grant%0d: grant=%h idx=%0d want %h/%0d", k, grant, grant_idx, exp, k % 8);
            end
            step();
            total++;
            if (grant !== 8'h00 || grant_valid !== 1'b0) begin
                bad++;
                $display("FAIL rotation_idle%0d: grant=%h valid=%b want 00/0", k, grant, grant_valid);
            end
        end
        done = 1'b0;
        req  = 8'h00;
        step();
    endtask

    task automatic test_wrap();
        do_reset();
        req = 8'h20;
        step();
        done = 1'b1;
        step();
        done = 1'b0;
        req  = 8'h21;
        step();
        total++;
        if (grant !== 8'h01 || grant_idx !== 3'd0) begin
            bad++;
            $display("FAIL wrap_search: grant=%h idx=%0d want 01/0", grant, grant_idx);
        end
        done = 1'b1;
        step();
        done = 1'b0;
        step();
        total++;
        if (grant !== 8'h20 || grant_idx !== 3'd5) begin
            bad++;
            $display("FAIL wrap_ptr1: grant=%h idx=%0d want 20/5", grant, grant_idx);
        end
        req = 8'h00;
        step();
    endtask

    task automatic test_timeout();
        do_reset();
        req = 8'h08;
        for (int c = 0; c < 4; c++) begin
            step();
            total++;
            if (grant !== 8'h08 || grant_valid !== 1'b1) begin
                bad++;
                $display("FAIL timeout_hold%0d: grant=%h valid=%b want 08/1", c, grant, grant_valid);
            end
        end
        step();
        total++;
        if (grant !== 8'h00 || grant_valid !== 1'b0 || grant_idx !== 3'd3) begin
            bad++;
            $display("FAIL timeout_release: grant=%h valid=%b idx=%0d want 00/0/3", grant, grant_valid, grant_idx);
        end
        step();
        total++;
        if (grant !== 8'h08 || grant_idx !== 3'd3) begin
            bad++;
            $display("FAIL timeout_regrant: grant=%h idx=%0d want 08/3", grant, grant_idx);
        end
        req = 8'h00;
        step();
        step();
    endtask

    task automatic test_drop();
        do_reset();
        req = 8'h02;
        step();
        req = 8'h40;
        step();
        total++;
        if (grant !== 8'h00 || grant_valid !== 1'b0) begin
            bad++;
            $display("FAIL drop_release: grant=%h valid=%b want 00/0", grant, grant_valid);
        end
        step();
        total++;
        if (grant !== 8'h40 || grant_idx !== 3'd6) begin
            bad++;
            $display("FAIL drop_next: grant=%h idx=%0d want 40/6", grant, grant_idx);
        end
        req = 8'h00;
        step();
    endtask

    task automatic test_no_preempt();
        do_reset();
        req = 8'h04;
        step();
        req = 8'h05;
        step();
        step();
        total++;
        if (grant !== 8'h04 || grant_idx !== 3'd2) begin
            bad++;
            $display("FAIL no_preempt: grant=%h idx=%0d want 04/2", grant, grant_idx);
        end
        done = 1'b1;
        step();
        done = 1'b0;
        step();
        total++;
        if (grant !== 8'h01 || grant_idx !== 3'd0) begin
            bad++;
            $display("FAIL no_preempt_next: grant=%h idx=%0d want 01/0", grant, grant_idx);
        end
        req = 8'h00;
        step();
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 8'h30;
        step();
        req = 8'h10;
        done = 1'b1;
        step();
        done = 1'b0;
        step();
        total++;
        if (grant !== 8'h10) begin
            bad++;
            $display("FAIL async_setup: grant=%h want 10", grant);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (grant !== 8'h00 || grant_valid !== 1'b0 || grant_idx !== 3'd0) begin
            bad++;
            $display("FAIL async_reset: grant=%h valid=%b idx=%0d want 00/0/0", grant, grant_valid, grant_idx);
        end
        #1;
        rst = 1'b0;
        req = 8'h11;
        step();
        total++;
        if (grant !== 8'h01 || grant_idx !== 3'd0) begin
            bad++;
            $display("FAIL async_after: grant=%h idx=%0d want 01/0", grant, grant_idx);
        end
        req = 8'h00;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_wrap();
        test_timeout();
        test_drop();
        test_no_preempt();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
